l2_port_arbiter: RTL and testbench
==================================

Name: l2_port_arbiter

Overview:
- Two-requester arbiter sharing the single L2/memory port between two masters, e.g. the L1 instruction and L1 data controllers or two processor cores.
- Both sides use the team's ce/rw/RDY handshake:
  - The requester holds ce with addr, rw and data until it sees RDY rise and then fall.
  - The requester then drops ce.
- The arbiter picks one requester round-robin and latches its request onto the downstream port.
- It relays RDY and read data back to the granted requester only.
- A watchdog terminates transactions the downstream never acknowledges.

Parameters:
- ADDR_W, 24, address width.
- DATA_W, 8, data width.
- TIMEOUT, 1024, maximum cycles in BUSY without m_rdy before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s0_ce  in  1  requester 0 chip enable (request).
- s0_rw  in  1  requester 0 direction; 1 = read, 0 = write.
- s0_addr  in  ADDR_W  requester 0 address.
- s0_wdata  in  DATA_W  requester 0 write data.
- s0_rdata  out  DATA_W  read data to requester 0.
- s0_rdy  out  1  ready to requester 0.
- s1_ce, s1_rw, s1_addr, s1_wdata, s1_rdata, s1_rdy: same as the s0_* ports, for requester 1.
- m_ce  out  1  downstream chip enable.
- m_rw  out  1  downstream direction.
- m_addr  out  ADDR_W  downstream address.
- m_wdata  out  DATA_W  downstream write data.
- m_rdata  in  DATA_W  downstream read data; valid while m_rdy is 1.
- m_rdy  in  1  downstream ready.
- grant  out  2  one-hot owner of the port; 00 when idle.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; m_ce, m_rw, m_addr, m_wdata, grant, timeout_err all 0.
  - Round-robin pointer favours requester 0; watchdog counter 0.
- IDLE:
  - Sample s0_ce and s1_ce each cycle.
  - If exactly one is high, grant it.
  - If both are high, grant the one not served last; after reset, requester 0 wins.
  - On grant, at the same edge: latch the winner's rw, addr and wdata into the m_* registers; set m_ce=1 and grant one-hot; go to BUSY.
  - Latency: request sampled at edge N gives m_ce=1 after edge N.
- BUSY:
  - m_ce=1; watchdog increments each cycle.
  - m_rdy=1 → DONE.
  - Watchdog reaching TIMEOUT-1 with m_rdy still 0 → ERR.
- DONE:
  - m_ce stays 1.
  - The granted s_rdy follows m_rdy combinationally; the granted s_rdata follows m_rdata.
  - m_rdy=0 → RELEASE, clearing m_ce at that edge.
- ERR:
  - For one cycle: m_ce=0, timeout_err=1, granted s_rdy=1, granted s_rdata=0.
  - Then → RELEASE.
- RELEASE:
  - m_ce=0 and grant is held.
  - When the granted s_ce is 0: go to IDLE, clear grant, set the pointer to "other requester preferred".
- Relay rules:
  - The non-granted s_rdy is always 0; its s_rdata is always 0.
  - In IDLE, BUSY and RELEASE both s_rdy are 0.
- Latched fields: m_addr, m_rw and m_wdata are stable for the whole transaction, even if the requester changes its inputs.
- Boundary conditions:
  - m_rdy high while in IDLE or RELEASE is ignored.
  - If the granted requester drops s_ce early, during BUSY, the downstream transaction still completes; RELEASE then exits immediately.
  - If m_rdy is already 1 on the first BUSY cycle, go to DONE after one cycle; the minimum transaction is IDLE → BUSY → DONE → RELEASE → IDLE.
  - A requester holding ce continuously is re-granted only after the other requester has had its turn, if the other is requesting.
  - With TIMEOUT=0 the watchdog is never armed.
  - Asserting rst_n mid-transaction drops m_ce and grant asynchronously and discards the transaction.
- Widths: the watchdog counter is $clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Package l2_bus_pkg holds:
  - the state enum (IDLE, BUSY, DONE, ERR, RELEASE);
  - the ADDR_W and DATA_W defaults;
  - the GRANT_NONE, GRANT_S0 and GRANT_S1 constants.
- One sub-module, rr_pick2, is natural. It is combinational: inputs are the two requests and the pointer; outputs are the one-hot winner and a valid flag.

Test Plan:
- Single read: s0_ce=1, rw=1, addr=0x00ABCD; downstream raises m_rdy two cycles after m_ce with m_rdata=0x5A.
  - Required: m_addr=0x00ABCD and m_ce rise one cycle after the request.
  - s0_rdy=1 and s0_rdata=0x5A for as long as m_rdy is high; s1_rdy stays 0.
- Simultaneous requests: s0_ce and s1_ce both high from reset and held.
  - Required: grant order 01, 10, 01.
  - Requester 1's write (addr 0x000010, data 0x3C) appears on m_* only after s0 drops ce.
- Input stability: s0 changes addr to 0xFFFFFF while in BUSY.
  - Required: m_addr holds the originally latched value until RELEASE.
- Watchdog: TIMEOUT=8, m_rdy held at 0.
  - Required: timeout_err and s0_rdy pulse for one cycle eight cycles after m_ce rose; s0_rdata=0; m_ce=0; the port returns to IDLE after s0 drops ce.
- Reset mid-transaction: assert rst_n=0 while in DONE.
  - Required: m_ce, grant and s0_rdy go to 0 immediately without waiting for clk; the next request after release is granted to requester 0 first.
- Spurious ready: pulse m_rdy while in IDLE.
  - Required: no s_rdy, no state change.

Source files
------------

// File: rtl/l2_bus_pkg.sv
// Shared types and constants for the L2 port arbiter and its helpers.
package l2_bus_pkg;

    localparam int unsigned ADDR_W_DEF = 24;
    localparam int unsigned DATA_W_DEF = 8;

    // One-hot ownership of the downstream port.
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        BUSY,
        DONE,
        ERR,
        RELEASE
    } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: one-hot winner among two requests given a preference bit.
module rr_pick2
    import l2_bus_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       prefer1,
    output logic [1:0] win,
    output logic       valid
);

    // Requester 0 wins when alone or when it is the preferred side of a tie.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        win = GRANT_NONE;
        if (req0 && (!req1 || !prefer1)) begin
            win = GRANT_S0;
        end else if (req1) begin
            win = GRANT_S1;
        end
        valid = req0 | req1;
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one ce/rw/RDY memory port between two requesters,
// with a watchdog that aborts transactions the downstream never acknowledges.
module l2_port_arbiter
    import l2_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_ce,
    input  logic              s0_rw,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_wdata,
    output logic [DATA_W-1:0] s0_rdata,
    output logic              s0_rdy,
    input  logic              s1_ce,
    input  logic              s1_rw,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_wdata,
    output logic [DATA_W-1:0] s1_rdata,
    output logic              s1_rdy,
    output logic              m_ce,
    output logic              m_rw,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rdy,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    // Watchdog is sized to hold TIMEOUT; a disabled watchdog keeps a 1-bit idle counter.
    localparam int unsigned        WD_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]    WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WD_W-1:0]    WD_MAX  = '1;

    state_e            state_q;
    state_e            state_d;
    logic              prefer1_q;
    logic [WD_W-1:0]   wd_cnt_q;
    logic [1:0]        win;
    logic              win_valid;
    logic              own_ce;
    logic              wd_fire;
    logic              rly_rdy;
    logic [DATA_W-1:0] rly_data;

    rr_pick2 u_pick (
        .req0    (s0_ce),
        .req1    (s1_ce),
        .prefer1 (prefer1_q),
        .win     (win),
        .valid   (win_valid)
    );

    assign own_ce  = (grant[0] & s0_ce) | (grant[1] & s1_ce);
    assign wd_fire = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST) && !m_rdy;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the transaction life cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_valid) state_d = BUSY;
            BUSY:    if (m_rdy) state_d = DONE;
                     else if (wd_fire) state_d = ERR;
            DONE:    if (!m_rdy) state_d = DONE == DONE ? RELEASE : RELEASE;
            ERR:     state_d = RELEASE;
            RELEASE: if (!own_ce) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Downstream request registers, ownership, round-robin pointer and watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ce      <= 1'b0;
            m_rw      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            grant     <= GRANT_NONE;
            prefer1_q <= 1'b0;
            wd_cnt_q  <= '0;
        end else begin
            m_ce <= (state_d == BUSY) || (state_d == DONE);
            if (state_q == IDLE && win_valid) begin
                grant    <= win;
                m_rw     <= win[1] ? s1_rw    : s0_rw;
                m_addr   <= win[1] ? s1_addr  : s0_addr;
                m_wdata  <= win[1] ? s1_wdata : s0_wdata;
                wd_cnt_q <= '0;
            end
            if (state_q == BUSY && TIMEOUT != 0 && wd_cnt_q != WD_MAX) begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
            if (state_q == RELEASE && !own_ce) begin
                grant     <= GRANT_NONE;
                prefer1_q <= grant[0];
            end
        end
    end

    // Relay ready/data to the owner only: live in DONE, forced ready with zero data in ERR.
    always_comb begin
        rly_rdy  = 1'b0;
        rly_data = '0;
        if (state_q == DONE) begin
            rly_rdy  = m_rdy;
            rly_data = m_rdata;
        end else if (state_q == ERR) begin
            rly_rdy  = 1'b1;
        end
    end

    assign s0_rdy      = grant[0] & rly_rdy;
    assign s1_rdy      = grant[1] & rly_rdy;
    assign s0_rdata    = grant[0] ? rly_data : '0;
    assign s1_rdata    = grant[1] ? rly_data : '0;
    assign timeout_err = (state_q == ERR);

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: randomized requesters, a downstream memory model,
// and a transaction-level arbitration model that predicts the order of downstream grants.
module tb_l2_port_arbiter;
    import l2_bus_pkg::*;

    localparam int AW    = 24;
    localparam int DW    = 8;
    localparam int TO    = 8;
    localparam int LIMIT = 300;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s0_ce = 1'b0, s0_rw = 1'b0, s1_ce = 1'b0, s1_rw = 1'b0;
    logic [AW-1:0] s0_addr = '0, s1_addr = '0;
    logic [DW-1:0] s0_wdata = '0, s1_wdata = '0;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic          s0_rdy, s1_rdy;
    logic          m_ce, m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_rdy = 1'b0;
    logic [1:0]    grant;
    logic          timeout_err;

    always #5 clk = ~clk;

    l2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_ce(s0_ce), .s0_rw(s0_rw), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
        .s0_rdata(s0_rdata), .s0_rdy(s0_rdy),
        .s1_ce(s1_ce), .s1_rw(s1_rw), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
        .s1_rdata(s1_rdata), .s1_rdy(s1_rdy),
        .m_ce(m_ce), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_rdy(m_rdy), .grant(grant), .timeout_err(timeout_err)
    );

    typedef struct {
        int            port;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            early;
        bit            scram;
        bit            to;
        bit            chk_lat;
    } txn_t;

    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];
    txn_t lst0[$];
    txn_t lst1[$];
    int   model_last = 1;
    logic [DW-1:0] dmem [logic [AW-1:0]];
    logic [DW-1:0] smem [logic [AW-1:0]];
    int   ds_delay = -1;
    int   ds_hold = -1;
    bit   ds_noack = 1'b0;
    bit   ds_idle = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [DW-1:0] dmem_rd(input logic [AW-1:0] a);
        return dmem.exists(a) ? dmem[a] : mem_init(a);
    endfunction

    function automatic logic [DW-1:0] smem_rd(input logic [AW-1:0] a);
        return smem.exists(a) ? smem[a] : mem_init(a);
    endfunction

    function automatic logic rdy_of(input int p);
        return (p != 0) ? s1_rdy : s0_rdy;
    endfunction

    function automatic txn_t mk(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.port = p; t.rw = rw; t.addr = a; t.wdata = d;
        t.early = 1'b0; t.scram = 1'b0; t.to = 1'b0; t.chk_lat = 1'b0;
        return t;
    endfunction

    function automatic txn_t rand_txn(input int p, input bit allow_early);
        txn_t t;
        t = mk(p, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom),
               DW'($urandom));
        t.early = allow_early && ($urandom_range(0, 5) == 0);
        t.scram = ($urandom_range(0, 3) == 0);
        return t;
    endfunction

    // Arbitration model: while both sides still have work they strictly alternate,
    // starting with the side not served last; leftovers go in list order.
    task automatic plan();
        int i0 = 0;
        int i1 = 0;
        int turn = 1 - model_last;
        while (i0 < lst0.size() || i1 < lst1.size()) begin
            if (i1 >= lst1.size()) turn = 0;
            else if (i0 >= lst0.size()) turn = 1;
            if (turn == 0) begin
                exp_q.push_back(lst0[i0]); i0++;
            end else begin
                exp_q.push_back(lst1[i1]); i1++;
            end
            model_last = turn;
            turn = 1 - turn;
        end
    endtask

    task automatic drive_req(input int p, input logic ce, input logic rw,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            s0_ce = ce; s0_rw = rw; s0_addr = a; s0_wdata = d;
        end else begin
            s1_ce = ce; s1_rw = rw; s1_addr = a; s1_wdata = d;
        end
    endtask

    // One requester transaction following the ce/RDY handshake.
    task automatic req_txn(input txn_t t);
        int n;
        logic [1:0] own;
        own = (t.port != 0) ? GRANT_S1 : GRANT_S0;
        drive_req(t.port, 1'b1, t.rw, t.addr, t.wdata);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant != own && n < LIMIT);
        if (grant != own) begin
            check("grant_wait", 64'(grant), 64'(own));
            drive_req(t.port, 1'b0, 1'b0, '0, '0);
            return;
        end
        if (t.chk_lat) check("grant_latency", 64'(n), 64'd1);
        if (t.scram) drive_req(t.port, 1'b1, ~t.rw, {AW{1'b1}}, ~t.wdata);
        if (t.early) begin
            drive_req(t.port, 1'b0, 1'b0, '0, '0);
            n = 0;
            while (grant == own && n < LIMIT) begin @(negedge clk); n++; end
            if (grant == own) check("early_release_wait", 64'(grant), 64'(GRANT_NONE));
        end else begin
            n = 0;
            while (!rdy_of(t.port) && n < LIMIT) begin @(negedge clk); n++; end
            if (!rdy_of(t.port)) check("rdy_rise_wait", 64'(rdy_of(t.port)), 64'd1);
            n = 0;
            while (rdy_of(t.port) && n < LIMIT) begin @(negedge clk); n++; end
            if (rdy_of(t.port)) check("rdy_fall_wait", 64'(rdy_of(t.port)), 64'd0);
            drive_req(t.port, 1'b0, 1'b0, '0, '0);
        end
        @(negedge clk);
    endtask

    task automatic run_list(input int p);
        if (p == 0) begin
            for (int i = 0; i < lst0.size(); i++) req_txn(lst0[i]);
        end else begin
            for (int i = 0; i < lst1.size(); i++) req_txn(lst1[i]);
        end
    endtask

    task automatic run_both();
        plan();
        fork
            run_list(0);
            run_list(1);
        join
        lst0.delete();
        lst1.delete();
    endtask

    task automatic wait_mce_low();
        int n = 0;
        while (m_ce && n < LIMIT) begin @(negedge clk); n++; end
        if (m_ce) check("ds_mce_release", 64'(m_ce), 64'd0);
    endtask

    // Downstream memory: acknowledges after a delay, holds RDY a few cycles, or never acks.
    initial begin : downstream
        int d;
        int h;
        forever begin
            @(negedge clk);
            if (rst_n && m_ce) begin
                ds_idle = 1'b0;
                if (ds_noack) begin
                    wait_mce_low();
                end else begin
                    d = (ds_delay >= 0) ? ds_delay : int'($urandom_range(0, 5));
                    h = (ds_hold >= 0) ? ds_hold : int'($urandom_range(2, 4));
                    repeat (d) @(negedge clk);
                    #1;
                    if (m_rw) begin
                        m_rdata = dmem_rd(m_addr);
                    end else begin
                        dmem[m_addr] = m_wdata;
                        m_rdata = DW'($urandom);
                    end
                    m_rdy = 1'b1;
                    repeat (h) @(negedge clk);
                    #1;
                    m_rdy = 1'b0;
                    m_rdata = '0;
                    wait_mce_low();
                end
                ds_idle = 1'b1;
            end
        end
    end

    // Monitor: pops the predicted transaction when m_ce rises and checks every relay cycle.
    initial begin : monitor
        txn_t          cur;
        bit            active = 1'b0;
        bit            prev_mce = 1'b0;
        bit            prev_to = 1'b0;
        bit            saw_rdy = 1'b0;
        int            cyc = 0;
        int            rise_cyc = 0;
        logic [DW-1:0] exp_rd = '0;
        logic          own_rdy, oth_rdy;
        logic [DW-1:0] own_rdata, oth_rdata;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                active = 1'b0; prev_mce = 1'b0; prev_to = 1'b0;
                continue;
            end
            if (prev_to) check("to_pulse_width", 64'(timeout_err), 64'd0);
            prev_to = timeout_err;
            if (active && grant == GRANT_NONE) begin
                check("txn_got_rdy", 64'(saw_rdy), 64'd1);
                active = 1'b0;
            end
            if (m_ce && !prev_mce) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_txn_addr", 64'(m_addr), 64'hDEAD_BEEF_0000);
                end else begin
                    cur = exp_q.pop_front();
                    active = 1'b1;
                    saw_rdy = 1'b0;
                    rise_cyc = cyc;
                    check("grant", 64'(grant), 64'((cur.port != 0) ? GRANT_S1 : GRANT_S0));
                    if (cur.rw) exp_rd = smem_rd(cur.addr);
                    else smem[cur.addr] = cur.wdata;
                end
            end
            prev_mce = m_ce;
            if (active) begin
                check("m_fields", {m_rw, m_addr, m_wdata}, {cur.rw, cur.addr, cur.wdata});
                own_rdy   = (cur.port != 0) ? s1_rdy : s0_rdy;
                own_rdata = (cur.port != 0) ? s1_rdata : s0_rdata;
                oth_rdy   = (cur.port != 0) ? s0_rdy : s1_rdy;
                oth_rdata = (cur.port != 0) ? s0_rdata : s1_rdata;
                check("other_rdy_rdata", 64'({oth_rdy, oth_rdata}), 64'd0);
                if (own_rdy) begin
                    saw_rdy = 1'b1;
                    if (cur.to) begin
                        check("to_err", 64'(timeout_err), 64'd1);
                        check("to_latency", 64'(cyc - rise_cyc), 64'(TO));
                        check("to_rdata", 64'(own_rdata), 64'd0);
                        check("to_mce", 64'(m_ce), 64'd0);
                    end else begin
                        check("rdy_no_to", 64'(timeout_err), 64'd0);
                        check("rdy_follows_mrdy", 64'(m_rdy), 64'd1);
                        check("rdata", 64'(own_rdata), 64'(cur.rw ? exp_rd : m_rdata));
                    end
                end else begin
                    check("to_without_rdy", 64'(timeout_err), 64'd0);
                end
            end else begin
                check("idle_outputs", 64'({m_ce, grant, s0_rdy, s1_rdy, timeout_err}), 64'd0);
            end
        end
    end

    initial begin : guard
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_m_ce", 64'(m_ce), 64'd0);
        check("rst_grant", 64'(grant), 64'(GRANT_NONE));
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_m_fields", {m_rw, m_addr, m_wdata}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Spurious ready while idle must be ignored.
        m_rdy = 1'b1; m_rdata = 8'hFF;
        repeat (3) @(negedge clk);
        m_rdy = 1'b0; m_rdata = '0;
        @(negedge clk);
        check("spurious_grant", 64'(grant), 64'(GRANT_NONE));

        // Simultaneous contention from reset; requester 1 opens with write 0x10 <- 0x3C.
        lst0.push_back(rand_txn(0, 1'b0));
        lst0[0].chk_lat = 1'b1;
        for (int i = 0; i < 7; i++) lst0.push_back(rand_txn(0, 1'b1));
        lst1.push_back(mk(1, 1'b0, 24'h000010, 8'h3C));
        for (int i = 0; i < 7; i++) lst1.push_back(rand_txn(1, 1'b1));
        run_both();

        // Directed single read with latched-field stability (address scrambled during BUSY).
        dmem[24'h00ABCD] = 8'h5A;
        smem[24'h00ABCD] = 8'h5A;
        ds_delay = 2; ds_hold = 3;
        lst0.push_back(mk(0, 1'b1, 24'h00ABCD, 8'h00));
        lst0[0].chk_lat = 1'b1;
        lst0[0].scram = 1'b1;
        run_both();
        ds_delay = -1; ds_hold = -1;

        // Read back requester 1's write through requester 0.
        lst0.push_back(mk(0, 1'b1, 24'h000010, 8'h00));
        run_both();

        // Watchdog abort.
        ds_noack = 1'b1;
        lst0.push_back(mk(0, 1'b1, 24'h000123, 8'h00));
        lst0[0].to = 1'b1;
        run_both();
        ds_noack = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of DONE.
        ds_delay = 1; ds_hold = 12;
        lst0.push_back(mk(0, 1'b1, 24'h000321, 8'h00));
        plan();
        lst0.delete();
        drive_req(0, 1'b1, 1'b1, 24'h000321, 8'h00);
        n = 0;
        while (!s0_rdy && n < LIMIT) begin @(negedge clk); n++; end
        check("reset_reached_done", 64'(s0_rdy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_m_ce", 64'(m_ce), 64'd0);
        check("rst_async_grant", 64'(grant), 64'(GRANT_NONE));
        check("rst_async_s0_rdy", 64'(s0_rdy), 64'd0);
        drive_req(0, 1'b0, 1'b0, '0, '0);
        n = 0;
        do begin @(negedge clk); n++; end while (!ds_idle && n < LIMIT);
        check("ds_idle_after_reset", 64'(ds_idle), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ds_delay = -1; ds_hold = -1;
        model_last = 1;
        @(negedge clk);

        // After reset, a tie must go to requester 0 again.
        lst0.push_back(rand_txn(0, 1'b0));
        lst0.push_back(rand_txn(0, 1'b1));
        lst1.push_back(rand_txn(1, 1'b0));
        lst1.push_back(rand_txn(1, 1'b1));
        run_both();

        repeat (5) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
